// File: rtl/dmem_responder_if.sv
// Data-memory port between a core's load/store unit (master) and its responder (slave).
// Word-addressed requests with byte strobes; read data returns one cycle after the request.
interface dmem_responder_if;
   logic [31:0] dmem_addr_i;
   logic        dmem_we_i;
   logic        dmem_re_i;
   logic [31:0] dmem_wdata_i;
   logic [3:0]  dmem_wmask_i;
   logic [31:0] dmem_rdata_o;

   modport master (
      output dmem_addr_i,
      output dmem_we_i,
      output dmem_re_i,
      output dmem_wdata_i,
      output dmem_wmask_i,
      input  dmem_rdata_o
   );

   modport slave (
      input  dmem_addr_i,
      input  dmem_we_i,
      input  dmem_re_i,
      input  dmem_wdata_i,
      input  dmem_wmask_i,
      output dmem_rdata_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-strobed word RAM with registered read data, plus a 16-byte
// MMIO window holding a 64-bit cycle counter (tear-free LO/HI pair) and a TOHOST report register.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
   parameter string       INIT_FILE   = ""
) (
   input  logic               clk,
   input  logic               rst,
   dmem_responder_if.slave    dmem,
   output logic               err_o,
   output logic               tohost_valid_o,
   output logic [31:0]        tohost_data_o
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RAM_LIMIT = {1'b0, RAM_BASE} + 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      MMIO_MTIME_LO = 2'd0,
      MMIO_MTIME_HI = 2'd1,
      MMIO_TOHOST   = 2'd2,
      MMIO_RSVD     = 2'd3
   } mmio_reg_e;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0] rdata_q,        rdata_d;
   logic        err_q,          err_d;
   logic        tohost_valid_q, tohost_valid_d;
   logic [31:0] tohost_data_q,  tohost_data_d;
   logic [63:0] mtime_q;
   logic [31:0] mtime_hi_shadow_q, mtime_hi_shadow_d;

   logic [31:0] ram_off_s;
   logic [AW-1:0] ram_idx_s;
   logic        in_ram_s;
   logic        in_mmio_s;
   logic        unmapped_s;
   logic        ram_wr_s;
   logic [31:0] tohost_merged_s;
   mmio_reg_e   mmio_sel_s;
   logic        unused_ok;

   assign ram_off_s  = dmem.dmem_addr_i - RAM_BASE;
   assign ram_idx_s  = ram_off_s[AW+1:2];
   assign in_ram_s   = ({1'b0, dmem.dmem_addr_i} >= {1'b0, RAM_BASE}) &&
                       ({1'b0, dmem.dmem_addr_i} <  RAM_LIMIT);
   assign in_mmio_s  = (dmem.dmem_addr_i[31:4] == MMIO_BASE[31:4]);
   assign unmapped_s = !in_ram_s && !in_mmio_s;
   assign mmio_sel_s = mmio_reg_e'(dmem.dmem_addr_i[3:2]);
   assign unused_ok  = ^{dmem.dmem_addr_i[1:0], ram_off_s[31:AW+2], ram_off_s[1:0]};

   // TOHOST candidate value: strobed bytes from wdata, others kept from the current register
   always_comb begin
      tohost_merged_s = tohost_data_q;
      for (int b = 0; b < 4; b++) begin
         if (dmem.dmem_wmask_i[b]) begin
            tohost_merged_s[8*b +: 8] = dmem.dmem_wdata_i[8*b +: 8];
         end else begin
            tohost_merged_s[8*b +: 8] = tohost_data_q[8*b +: 8];
         end
      end
   end

   // Request decode: next read data, error pulse, TOHOST update, shadow latch, RAM write enable
   always_comb begin
      rdata_d           = rdata_q;
      err_d             = (dmem.dmem_we_i || dmem.dmem_re_i) && unmapped_s;
      tohost_valid_d    = 1'b0;
      tohost_data_d     = tohost_data_q;
      mtime_hi_shadow_d = mtime_hi_shadow_q;
      ram_wr_s          = 1'b0;

      if (dmem.dmem_we_i) begin
         // Reset suppresses the write so a same-cycle request cannot disturb RAM
         ram_wr_s = in_ram_s && !rst;
         if (in_mmio_s && (mmio_sel_s == MMIO_TOHOST) && (tohost_merged_s != 32'd0)) begin
            tohost_data_d  = tohost_merged_s;
            tohost_valid_d = 1'b1;
         end else begin
            tohost_data_d  = tohost_data_q;
         end
      end else if (dmem.dmem_re_i) begin
         if (in_ram_s) begin
            rdata_d = mem_q[ram_idx_s];
         end else if (in_mmio_s) begin
            case (mmio_sel_s)
               MMIO_MTIME_LO: begin
                  rdata_d           = mtime_q[31:0];
                  mtime_hi_shadow_d = mtime_q[63:32];
               end
               MMIO_MTIME_HI: rdata_d = mtime_hi_shadow_q;
               MMIO_TOHOST:   rdata_d = tohost_data_q;
               MMIO_RSVD:     rdata_d = 32'd0;
               default:       rdata_d = 32'd0;
            endcase
         end else begin
            rdata_d = 32'd0;
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Byte-lane RAM writes; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_wr_s) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem.dmem_wmask_i[b]) begin
               mem_q[ram_idx_s][8*b +: 8] <= dmem.dmem_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Output, MMIO and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q           <= 32'd0;
         err_q             <= 1'b0;
         tohost_valid_q    <= 1'b0;
         tohost_data_q     <= 32'd0;
         mtime_q           <= 64'd0;
         mtime_hi_shadow_q <= 32'd0;
      end else begin
         rdata_q           <= rdata_d;
         err_q             <= err_d;
         tohost_valid_q    <= tohost_valid_d;
         tohost_data_q     <= tohost_data_d;
         mtime_q           <= mtime_q + 64'd1;
         mtime_hi_shadow_q <= mtime_hi_shadow_d;
      end
   end

   assign dmem.dmem_rdata_o = rdata_q;
   assign err_o             = err_q;
   assign tohost_valid_o    = tohost_valid_q;
   assign tohost_data_o     = tohost_data_q;
endmodule
